// File: rtl/tmp_display_ctrl_if.sv
// Sample handshake between the sensor reader (master) and the display controller (slave).
interface tmp_display_ctrl_if #(
  parameter int TEMP_W = 13
);
  logic              temp_valid;
  logic [TEMP_W-1:0] temp_raw;
  logic              ready;

  modport master (output temp_valid, output temp_raw, input ready);
  modport slave  (input temp_valid, input temp_raw, output ready);
endinterface

// File: rtl/tmp_display_ctrl.sv
// Temperature display controller: signed fixed-point sample -> sign + 3 BCD digits via
// iterative double-dabble, then colour band selection, per-channel fade and RGB PWM.
module tmp_display_ctrl #(
  parameter int TEMP_W    = 13,
  parameter int FRAC_BITS = 4,
  parameter int PWM_MAX   = 510,
  parameter int FADE_DIV  = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  tmp_display_ctrl_if.slave   s_if,
  output logic                disp_valid,
  output logic                temp_neg,
  output logic [3:0]          temp_h,
  output logic [3:0]          temp_t,
  output logic [3:0]          temp_u,
  output logic [2:0]          led,
  output logic                dbg_state,
  output logic [23:0]         dbg_target,
  output logic [23:0]         dbg_level
);
  localparam int MAG_W    = TEMP_W - FRAC_BITS;
  localparam int CNT_W    = $clog2(MAG_W + 1);
  localparam int SR_W     = 16 + MAG_W;
  localparam int PWM_W    = $clog2(PWM_MAX + 1);
  localparam int DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int DIV_LAST = (FADE_DIV > 0) ? FADE_DIV - 1 : 0;

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
  logic [MAG_W-1:0]  mag_q, mag_d, mag_in;
  logic              neg_q, neg_d;
  logic              disp_valid_q, disp_valid_d;
  logic              temp_neg_q, temp_neg_d;
  logic [11:0]       digits_q, digits_d;
  logic [23:0]       target_q, target_d;
  logic [23:0]       level_q, level_d;
  logic [PWM_W-1:0]  pwm_q, pwm_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        led_q, led_d;
  logic [TEMP_W-1:0] abs_raw;
  logic              tick;

  // Handshake: ready is high exactly in IDLE; a sample transfers on a clock edge where
  // temp_valid && ready. temp_valid while ready is low is dropped, never queued.
  assign s_if.ready = (state_q == S_IDLE);

  assign abs_raw = s_if.temp_raw[TEMP_W-1] ? (TEMP_W'(0) - s_if.temp_raw) : s_if.temp_raw;
  assign mag_in  = MAG_W'(abs_raw >> FRAC_BITS);

  function automatic logic [23:0] band(input logic n, input logic [MAG_W-1:0] m);
    logic [15:0] me;
    me = 16'(m);
    if (n || me <= 16'd10)  return 24'h180DF3;
    else if (me <= 16'd15)  return 24'h15D7EB;
    else if (me <= 16'd20)  return 24'h22DE6E;
    else if (me <= 16'd25)  return 24'h43C739;
    else if (me <= 16'd30)  return 24'hF2C10E;
    else if (me <= 16'd38)  return 24'hE4471C;
    else                    return 24'hFF0000;
  endfunction

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_adj[MAG_W + 4*i +: 4] >= 4'd5)
        sr_adj[MAG_W + 4*i +: 4] = sr_adj[MAG_W + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    sr_d         = sr_q;
    mag_d        = mag_q;
    neg_d        = neg_q;
    disp_valid_d = 1'b0;
    temp_neg_d   = temp_neg_q;
    digits_d     = digits_q;
    target_d     = target_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_if.temp_valid) begin
          neg_d   = s_if.temp_raw[TEMP_W-1];
          mag_d   = mag_in;
          sr_d    = {16'd0, mag_in};
          iter_d  = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (iter_q != CNT_W'(MAG_W)) begin
          sr_d   = sr_adj << 1;
          iter_d = iter_q + CNT_W'(1);
        end else begin
          // A non-zero thousands nibble means the magnitude exceeded 999.
          digits_d     = (sr_q[SR_W-1 -: 4] != 4'd0) ? 12'h999 : sr_q[MAG_W +: 12];
          temp_neg_d   = neg_q;
          target_d     = band(neg_q, mag_q);
          disp_valid_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tick  = (div_q == DIV_W'(DIV_LAST));
    div_d = tick ? '0 : div_q + DIV_W'(1);
    pwm_d = (pwm_q == PWM_W'(PWM_MAX)) ? '0 : pwm_q + PWM_W'(1);
    level_d = level_q;
    if (FADE_DIV == 0) begin
      level_d = target_q;
    end else if (tick) begin
      for (int i = 0; i < 3; i++) begin
        if (level_q[8*i +: 8] < target_q[8*i +: 8])
          level_d[8*i +: 8] = level_q[8*i +: 8] + 8'd1;
        else if (level_q[8*i +: 8] > target_q[8*i +: 8])
          level_d[8*i +: 8] = level_q[8*i +: 8] - 8'd1;
      end
    end
    led_d = 3'b000;
    for (int i = 0; i < 3; i++)
      led_d[i] = (pwm_q < PWM_W'(level_q[8*i +: 8]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      iter_q       <= '0;
      sr_q         <= '0;
      mag_q        <= '0;
      neg_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      temp_neg_q   <= 1'b0;
      digits_q     <= '0;
      target_q     <= '0;
      level_q      <= '0;
      pwm_q        <= '0;
      div_q        <= '0;
      led_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      sr_q         <= sr_d;
      mag_q        <= mag_d;
      neg_q        <= neg_d;
      disp_valid_q <= disp_valid_d;
      temp_neg_q   <= temp_neg_d;
      digits_q     <= digits_d;
      target_q     <= target_d;
      level_q      <= level_d;
      pwm_q        <= pwm_d;
      div_q        <= div_d;
      led_q        <= led_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign temp_neg   = temp_neg_q;
  assign temp_h     = digits_q[11:8];
  assign temp_t     = digits_q[7:4];
  assign temp_u     = digits_q[3:0];
  assign led        = led_q;
  assign dbg_state  = (state_q == S_CONVERT);
  assign dbg_target = target_q;
  assign dbg_level  = level_q;
endmodule

// File: tb/tb_tmp_display_ctrl.sv
// Bench for tmp_display_ctrl: directed and random samples against an arithmetic model,
// fade/PWM behaviour at FADE_DIV=4, protocol and mid-conversion reset.
module tb_tmp_display_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_valid, temp_neg, dbg_state;
  logic [3:0]  temp_h, temp_t, temp_u;
  logic [2:0]  led;
  logic [23:0] dbg_target, dbg_level;

  int checks = 0;
  int failures = 0;
  int disp_count = 0;
  logic [36:0] exp_q[$];

  tmp_display_ctrl_if #(.TEMP_W(13)) t_if ();

  tmp_display_ctrl #(.TEMP_W(13), .FRAC_BITS(4), .PWM_MAX(510), .FADE_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_if(t_if),
    .disp_valid(disp_valid), .temp_neg(temp_neg),
    .temp_h(temp_h), .temp_t(temp_t), .temp_u(temp_u),
    .led(led), .dbg_state(dbg_state), .dbg_target(dbg_target), .dbg_level(dbg_level)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // reference model: {neg, h, t, u, target}
  function automatic logic [36:0] model(input logic [12:0] raw);
    int v, m, h, t, u;
    logic n;
    logic [23:0] tgt;
    v = int'($signed(raw));
    n = (v < 0);
    m = (n ? -v : v) / 16;
    if (m > 999) begin h = 9; t = 9; u = 9; end
    else begin h = m / 100; t = (m / 10) % 10; u = m % 10; end
    if (n || m <= 10)  tgt = 24'h180DF3;
    else if (m < 16)   tgt = 24'h15D7EB;
    else if (m < 21)   tgt = 24'h22DE6E;
    else if (m < 26)   tgt = 24'h43C739;
    else if (m < 31)   tgt = 24'hF2C10E;
    else if (m < 39)   tgt = 24'hE4471C;
    else               tgt = 24'hFF0000;
    return {n, 4'(h), 4'(t), 4'(u), tgt};
  endfunction

  // scoreboard
  always begin
    logic [36:0] e;
    @(posedge clk); #1;
    if (rst_n && disp_valid) begin
      disp_count++;
      if (exp_q.size() == 0) chk("unexpected_disp", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("temp_neg", temp_neg, e[36]);
        chk("digits", {temp_h, temp_t, temp_u}, e[35:24]);
        chk("target", dbg_target, e[23:0]);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, t_if.ready, 1);
    chk({tag, "_disp"}, disp_valid, 0);
    chk({tag, "_neg"}, temp_neg, 0);
    chk({tag, "_digits"}, {temp_h, temp_t, temp_u}, 0);
    chk({tag, "_target"}, dbg_target, 0);
    chk({tag, "_level"}, dbg_level, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_state("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
  endtask

  // driver: one sample, latency and hold checks
  task automatic send(input logic [12:0] raw, input bit hold_chk);
    int n;
    logic [36:0] e;
    n = 0;
    while (!t_if.ready && n < 50) begin cyc(1); n++; end
    if (!t_if.ready) chk("ready_timeout", 0, 1);
    e = model(raw);
    exp_q.push_back(e);
    t_if.temp_valid = 1'b1;
    t_if.temp_raw   = raw;
    @(posedge clk); #1;
    t_if.temp_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!disp_valid && n < 40);
    chk("latency", n, 10);
    if (hold_chk) begin
      cyc(3);
      chk("hold_digits", {temp_neg, temp_h, temp_t, temp_u}, e[36:24]);
    end
  endtask

  initial begin
    logic [12:0] dir[8];
    int t, last, r, prev, bad, dirbad, c2, c1, c0, d0;
    logic [23:0] pl;
    dir = '{13'h0190, 13'h1FA8, 13'h0260, 13'h0270, 13'h0FFF, 13'h00A0, 13'h1000, 13'h0000};
    t_if.temp_valid = 1'b0;
    t_if.temp_raw   = '0;
    #1;
    check_reset_state("init");
    #20;
    @(negedge clk); rst_n = 1'b1;
    cyc(1);

    foreach (dir[i]) send(dir[i], 1'b1);
    for (int i = 0; i < 24; i++) send(13'($urandom_range(0, 8191)), i[0]);

    // temp_valid held through CONVERT: only the first sample converts
    d0 = disp_count;
    exp_q.push_back(model(13'h0190));
    t_if.temp_valid = 1'b1; t_if.temp_raw = 13'h0190;
    cyc(1);
    t_if.temp_raw = 13'h0270;
    cyc(8);
    t_if.temp_valid = 1'b0;
    cyc(30);
    chk("held_valid_one_disp", disp_count - d0, 1);

    // reset during iteration 4
    t_if.temp_valid = 1'b1; t_if.temp_raw = 13'h0FFF;
    cyc(1);
    t_if.temp_valid = 1'b0;
    cyc(4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_reset_state("midconv");
    d0 = disp_count;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    cyc(20);
    chk("no_disp_after_abort", disp_count - d0, 0);
    send(13'h0FFF, 1'b1);

    // fade up to FF0000 from reset
    do_reset();
    send(13'h0270, 1'b0);
    t = 0; last = -1; bad = 0;
    prev = int'(dbg_level[23:16]);
    while (int'(dbg_level[23:16]) != 255 && t < 1100) begin
      cyc(1); t++;
      r = int'(dbg_level[23:16]);
      if (dbg_level[15:0] != 16'h0) bad = 1;
      if (r != prev) begin
        chk("r_step", r, prev + 1);
        if (last >= 0) chk("r_interval", t - last, 4);
        last = t;
        prev = r;
      end
    end
    chk("r_final", dbg_level[23:16], 8'hFF);
    chk("r_rise_time_ok", (t >= 1017 && t <= 1020), 1);
    chk("gb_stay_zero", bad, 0);

    // PWM duty at R=FF, G=B=0
    c2 = 0; c1 = 0; c0 = 0;
    repeat (511) begin
      cyc(1);
      c2 += int'(led[2]); c1 += int'(led[1]); c0 += int'(led[0]);
    end
    chk("pwm_r_ff", c2, 255);
    chk("pwm_g_zero", c1, 0);
    chk("pwm_b_zero", c0, 0);

    // redirect mid-fade
    do_reset();
    send(13'h0270, 1'b0);
    cyc(400);
    chk("r_mid_above_43", dbg_level[23:16] > 8'h43, 1);
    send(13'h0190, 1'b0);
    pl = dbg_level; bad = 0; dirbad = 0; t = 0;
    while (dbg_level != 24'h43C739 && t < 1200) begin
      cyc(1); t++;
      for (int k = 0; k < 3; k++) begin
        if (int'(dbg_level[8*k +: 8]) - int'(pl[8*k +: 8]) > 1 ||
            int'(pl[8*k +: 8]) - int'(dbg_level[8*k +: 8]) > 1) bad = 1;
      end
      if (dbg_level[23:16] > pl[23:16]) dirbad = 1;
      pl = dbg_level;
    end
    chk("redirect_no_jump", bad, 0);
    chk("redirect_r_down", dirbad, 0);
    chk("redirect_final", dbg_level, 24'h43C739);

    cyc(5);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
